// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  // Word index to byte address, zero-extended to the 32-bit bus.
  function automatic logic [31:0] word_adr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface inst_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_adr;
  logic [31:0] wr_data;

  // master is the loader itself; slave is the host link / memory side.
  modport master (input in_valid, in_data, output in_ready, wr_en, wr_adr, wr_data);
  modport slave  (output in_valid, in_data, input in_ready, wr_en, wr_adr, wr_data);
endinterface

// File: rtl/inst_mem_loader_word_assembler.sv
// 8->32 little-endian assembler: earlier bytes land in the low lanes.
module word_assembler
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word_next,
  output logic        word_ready
);
  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] cnt;
  logic [23:0]   sr;

  // Only three bytes are ever stored; the fourth completes the word on the fly.
  assign word_next  = {din, sr};
  assign word_ready = en && (cnt == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      sr  <= {din, sr[23:8]};
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, CPU held until done.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int COUNT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  inst_mem_loader_if.master  bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);
  state_t                     state;
  logic [LEN_BYTES*8-1:0]     length;
  logic [15:0]                word_index;
  logic                       accept, rearm, asm_en, word_ready;
  logic [31:0]                word_next;
  logic [15:0]                full_len;

  // in_ready is forced low while reset is held, even though state is LEN_HI.
  assign bus.in_ready = rst_n && (state == LEN_HI || state == LEN_LO || state == DATA);
  assign accept       = bus.in_valid && bus.in_ready;
  assign rearm        = start && (state == DONE || state == ERR);
  assign asm_en       = accept && (state == DATA);
  assign full_len     = {length[15:8], bus.in_data};

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (rearm),
    .en         (asm_en),
    .din        (bus.in_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LEN_HI;
      length      <= '0;
      word_index  <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_adr  <= '0;
      bus.wr_data <= '0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        LEN_HI: if (accept) begin
          length[15:8] <= bus.in_data;
          state        <= LEN_LO;
        end
        LEN_LO: if (accept) begin
          length[7:0] <= bus.in_data;
          if (full_len == 16'd0) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (int'(full_len) > COUNT) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (word_ready) begin
          state       <= WRITE;
          bus.wr_en   <= 1'b1;
          bus.wr_adr  <= word_adr(word_index);
          bus.wr_data <= word_next;
        end
        WRITE: begin
          word_index <= word_index + 16'd1;
          if (word_index == length - 16'd1) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DONE, ERR: if (start) begin
          state      <= LEN_HI;
          length     <= '0;
          word_index <= '0;
          done       <= 1'b0;
          err        <= 1'b0;
          cpu_hold   <= 1'b1;
        end
        default: state <= LEN_HI;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader.
module tb_inst_mem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;
  int   checks = 0;
  int   errors = 0;

  int          wr_cnt = 0;
  logic [31:0] last_adr = '0;
  logic [31:0] last_data = '0;

  inst_mem_loader_if bus ();

  inst_mem_loader #(.COUNT(1024)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus.master),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.wr_en === 1'b1) begin
    wr_cnt++;
    last_adr  = bus.wr_adr;
    last_data = bus.wr_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stuck low, byte %h", b);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic gap_send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    send(b);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    #12;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", bus.wr_en); end
    checks++; if (bus.wr_adr !== 32'd0) begin errors++; $display("FAIL rst_wr_adr got %h exp 0", bus.wr_adr); end
    checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", bus.wr_data); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got %b exp 1", cpu_hold); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b exp 00", done, err); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_two_words();
    int base;
    base = wr_cnt;
    send(8'h00); send(8'h02);
    send(8'h14); send(8'h00); send(8'hA0);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL tw_hold_mid got %b exp 1", cpu_hold); end
    send(8'hE3);
    @(negedge clk); #1;
    checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL tw_w0_en got %b exp 1", bus.wr_en); end
    checks++; if (bus.wr_adr !== 32'd0) begin errors++; $display("FAIL tw_w0_adr got %h exp 0", bus.wr_adr); end
    checks++; if (bus.wr_data !== 32'hE3A00014) begin errors++; $display("FAIL tw_w0_data got %h exp E3A00014", bus.wr_data); end
    send(8'h01); send(8'h1A); send(8'hA0); send(8'hE3);
    @(negedge clk); #1;
    checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL tw_w1_en got %b exp 1", bus.wr_en); end
    checks++; if (bus.wr_adr !== 32'd4) begin errors++; $display("FAIL tw_w1_adr got %h exp 4", bus.wr_adr); end
    checks++; if (bus.wr_data !== 32'hE3A01A01) begin errors++; $display("FAIL tw_w1_data got %h exp E3A01A01", bus.wr_data); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL tw_done got done=%b hold=%b exp 1/0", done, cpu_hold); end
    checks++; if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL tw_idle got rdy=%b en=%b exp 0/0", bus.in_ready, bus.wr_en); end
    checks++; if (bus.wr_adr !== 32'd4) begin errors++; $display("FAIL tw_adr_hold got %h exp 4", bus.wr_adr); end
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL tw_count got %0d exp 2", wr_cnt - base); end
  endtask

  task automatic test_zero_len();
    int base;
    pulse_start();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL zl_rearm got done=%b hold=%b rdy=%b exp 0/1/1", done, cpu_hold, bus.in_ready); end
    base = wr_cnt;
    send(8'h00); send(8'h00);
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL zl_done got done=%b hold=%b exp 1/0", done, cpu_hold); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zl_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (wr_cnt !== base) begin errors++; $display("FAIL zl_writes got %0d exp 0", wr_cnt - base); end
  endtask

  task automatic test_gaps();
    int base;
    pulse_start();
    base = wr_cnt;
    gap_send(8'h00, 1); gap_send(8'h01, 5);
    gap_send(8'h78, 1); gap_send(8'h56, 5); gap_send(8'h34, 1);
    checks++; if (wr_cnt !== base) begin errors++; $display("FAIL gap_early_write got %0d exp 0", wr_cnt - base); end
    gap_send(8'h12, 5);
    @(negedge clk); #1;
    checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL gap_en got %b exp 1", bus.wr_en); end
    checks++; if (bus.wr_adr !== 32'd0) begin errors++; $display("FAIL gap_adr got %h exp 0", bus.wr_adr); end
    checks++; if (bus.wr_data !== 32'h12345678) begin errors++; $display("FAIL gap_data got %h exp 12345678", bus.wr_data); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || wr_cnt - base !== 1) begin errors++; $display("FAIL gap_done got done=%b writes=%0d exp 1/1", done, wr_cnt - base); end
  endtask

  task automatic test_overflow();
    int base;
    pulse_start();
    base = wr_cnt;
    send(8'h04); send(8'h01);
    @(negedge clk); #1;
    checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ov_err got err=%b hold=%b done=%b exp 1/1/0", err, cpu_hold, done); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ov_in_ready got %b exp 0", bus.in_ready); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1 || wr_cnt !== base) begin errors++; $display("FAIL ov_sticky got err=%b writes=%0d exp 1/0", err, wr_cnt - base); end
    pulse_start();
    checks++; if (err !== 1'b0 || cpu_hold !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ov_rearm got err=%b hold=%b rdy=%b exp 0/1/1", err, cpu_hold, bus.in_ready); end
  endtask

  task automatic test_full_count();
    int base;
    logic [15:0] w;
    base = wr_cnt;
    send(8'h04); send(8'h00);
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i);
      send(w[7:0]); send(w[15:8]); send(8'hA5); send(8'h5A);
      if (i == 511) begin
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fc_mid got hold=%b done=%b exp 1/0", cpu_hold, done); end
      end
    end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (wr_cnt - base !== 1024) begin errors++; $display("FAIL fc_count got %0d exp 1024", wr_cnt - base); end
    checks++; if (last_adr !== 32'd4092) begin errors++; $display("FAIL fc_last_adr got %0d exp 4092", last_adr); end
    checks++; if (last_data !== 32'h5AA503FF) begin errors++; $display("FAIL fc_last_data got %h exp 5AA503FF", last_data); end
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL fc_done got done=%b hold=%b exp 1/0", done, cpu_hold); end
  endtask

  task automatic test_mid_reset();
    int base;
    pulse_start();
    send(8'h00); send(8'h02); send(8'hAA); send(8'hBB);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (bus.wr_adr !== 32'd0 || bus.wr_data !== 32'd0) begin errors++; $display("FAIL mr_bus got adr=%h data=%h exp 0/0", bus.wr_adr, bus.wr_data); end
    checks++; if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL mr_ctl got rdy=%b en=%b exp 0/0", bus.in_ready, bus.wr_en); end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mr_status got hold=%b done=%b err=%b exp 1/0/0", cpu_hold, done, err); end
    @(negedge clk); rst_n = 1'b1;
    base = wr_cnt;
    send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk); #1;
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_adr !== 32'd0) begin errors++; $display("FAIL mr_new_adr got en=%b adr=%h exp 1/0", bus.wr_en, bus.wr_adr); end
    checks++; if (bus.wr_data !== 32'h44332211) begin errors++; $display("FAIL mr_new_data got %h exp 44332211", bus.wr_data); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || wr_cnt - base !== 1) begin errors++; $display("FAIL mr_done got done=%b writes=%0d exp 1/1", done, wr_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_gaps();
    test_overflow();
    test_full_count();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
